phy_rx_lane_ctrl: RTL and testbench



---
 rtl/phy_rx_pkg.sv | 19 +
 rtl/sat_cnt8.sv | 19 +
 rtl/phy_rx_lane_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_phy_rx_lane_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared encodings for the two-lane PHY receive lane controller.
package phy_rx_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned ERR_W   = 8;

  localparam logic [STATE_W-1:0] ST_DOWN    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_ALIGN   = 3'd2;
  localparam logic [STATE_W-1:0] ST_UP      = 3'd3;
  localparam logic [STATE_W-1:0] ST_RETRAIN = 3'd4;

  localparam logic [LANE_W-1:0] LANE_NONE = 2'b00;
  localparam logic [LANE_W-1:0] LANE_L0   = 2'b01;
  localparam logic [LANE_W-1:0] LANE_L1   = 2'b10;
  localparam logic [LANE_W-1:0] LANE_BOTH = 2'b11;

endpackage

// File: rtl/sat_cnt8.sv
// Saturating event counter, cleared only by reset.
module sat_cnt8
  import phy_rx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/phy_rx_lane_ctrl.sv
// Link bring-up and lane sequencing for the two-lane PHY receive path:
// picks the active lane set, aligns the first byte, then supervises the link.
module phy_rx_lane_ctrl
  import phy_rx_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned MAX_MISMATCH = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic               active0,
  input  logic               active1,
  input  logic               byte_valid0,
  input  logic               byte_valid1,
  output logic [LANE_W-1:0]  lane_en,
  output logic               link_up,
  output logic               datapath_rst,
  output logic               start_lane,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q, state_nxt;
  logic [LANE_W-1:0]  cand_q, cand_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   mm_q, mm_nxt;
  logic [LANE_W-1:0]  lane_en_q, lane_en_nxt;
  logic               link_up_q, link_up_nxt;
  logic               dp_rst_q, dp_rst_nxt;
  logic               start_q, start_nxt;
  logic               err_inc;

  logic [LANE_W-1:0]  act;
  logic [LANE_W-1:0]  vld;
  logic [CNT_W-1:0]   cnt_inc;
  logic               lost;
  logic               two_lane;

  assign act      = {active1, active0};
  assign vld      = {byte_valid1, byte_valid0} & lane_en_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign lost     = (act & lane_en_q) != lane_en_q;
  assign two_lane = (lane_en_q == LANE_BOTH);

  // State and registered outputs
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q   <= ST_DOWN;
      cand_q    <= LANE_NONE;
      cnt_q     <= '0;
      mm_q      <= '0;
      lane_en_q <= LANE_NONE;
      link_up_q <= 1'b0;
      dp_rst_q  <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cand_q    <= cand_nxt;
      cnt_q     <= cnt_nxt;
      mm_q      <= mm_nxt;
      lane_en_q <= lane_en_nxt;
      link_up_q <= link_up_nxt;
      dp_rst_q  <= dp_rst_nxt;
      start_q   <= start_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt   = state_q;
    cand_nxt    = cand_q;
    cnt_nxt     = cnt_q;
    mm_nxt      = mm_q;
    lane_en_nxt = lane_en_q;
    link_up_nxt = link_up_q;
    dp_rst_nxt  = dp_rst_q;
    start_nxt   = start_q;
    err_inc     = 1'b0;

    case (state_q)
      ST_DOWN: begin
        if (act != LANE_NONE) begin
          cand_nxt  = act;
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (act == LANE_NONE) begin
          state_nxt = ST_DOWN;
        end else if (act != cand_q) begin
          cand_nxt = act;
          cnt_nxt  = '0;
        end else if (cnt_inc == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_nxt     = '0;
          lane_en_nxt = cand_q;
          dp_rst_nxt  = 1'b0;
          state_nxt   = ST_ALIGN;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      ST_ALIGN: begin
        if (lost) begin
          state_nxt = ST_RETRAIN;
        end else if (two_lane) begin
          if (vld == LANE_BOTH) begin
            start_nxt = 1'b0;
            state_nxt = ST_UP;
          end else if (vld != LANE_NONE) begin
            err_inc   = 1'b1;
            state_nxt = ST_RETRAIN;
          end
        end else if (vld != LANE_NONE) begin
          // single-lane: only the enabled lane can be set in vld
          start_nxt = (vld == LANE_L1);
          state_nxt = ST_UP;
        end
      end

      ST_UP: begin
        if (lost) begin
          err_inc   = 1'b1;
          state_nxt = ST_RETRAIN;
        end else if (two_lane) begin
          if (byte_valid0 != byte_valid1) begin
            if (mm_q == CNT_W'(MAX_MISMATCH - 1)) begin
              err_inc   = 1'b1;
              state_nxt = ST_RETRAIN;
            end else begin
              mm_nxt = mm_q + CNT_W'(1);
            end
          end else begin
            mm_nxt = '0;
          end
        end
      end

      ST_RETRAIN: begin
        if (act == LANE_NONE) begin
          state_nxt = ST_DOWN;
        end else begin
          cand_nxt  = act;
          state_nxt = ST_SETTLE;
        end
      end

      default: begin
        state_nxt = ST_DOWN;
      end
    endcase

    // Outside ALIGN/UP the datapath is held in reset with no lanes enabled
    if ((state_nxt == ST_DOWN) || (state_nxt == ST_SETTLE) ||
        (state_nxt == ST_RETRAIN)) begin
      lane_en_nxt = LANE_NONE;
      link_up_nxt = 1'b0;
      dp_rst_nxt  = 1'b1;
    end
    if (state_nxt == ST_RETRAIN) begin
      cnt_nxt = '0;
      mm_nxt  = '0;
    end
    if (state_nxt == ST_ALIGN) begin
      link_up_nxt = 1'b0;
      mm_nxt      = '0;
    end
    if (state_nxt == ST_UP) begin
      link_up_nxt = 1'b1;
    end
  end

  sat_cnt8 u_err_cnt (
    .clk   (clk_4f),
    .reset (reset),
    .inc   (err_inc),
    .count (err_cnt)
  );

  assign lane_en      = lane_en_q;
  assign link_up      = link_up_q;
  assign datapath_rst = dp_rst_q;
  assign start_lane   = start_q;
  assign state        = state_q;

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Directed vector bench for phy_rx_lane_ctrl: table of per-cycle stimulus
// and expected registered outputs, plus an error-saturation sequence.
module tb_phy_rx_lane_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       active0, active1, byte_valid0, byte_valid1;
  logic [1:0] lane_en;
  logic       link_up, datapath_rst, start_lane;
  logic [7:0] err_cnt;
  logic [2:0] state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic       rst;
    logic [1:0] act;
    logic [1:0] bv;
    logic [2:0] st;
    logic [1:0] le;
    logic       lu;
    logic       dr;
    logic       sl;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_4f = ~clk_4f;

  phy_rx_lane_ctrl #(
    .SETTLE_CYC   (8),
    .MAX_MISMATCH (4),
    .CNT_W        (4)
  ) dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .active0      (active0),
    .active1      (active1),
    .byte_valid0  (byte_valid0),
    .byte_valid1  (byte_valid1),
    .lane_en      (lane_en),
    .link_up      (link_up),
    .datapath_rst (datapath_rst),
    .start_lane   (start_lane),
    .err_cnt      (err_cnt),
    .state        (state)
  );

  task automatic v(input logic rst, input logic [1:0] act, input logic [1:0] bv,
                   input logic [2:0] st, input logic [1:0] le, input logic lu,
                   input logic dr, input logic sl, input logic [7:0] err, input int n);
    vec_t e;
    e.rst = rst; e.act = act; e.bv = bv; e.st = st; e.le = le;
    e.lu = lu; e.dr = dr; e.sl = sl; e.err = err;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [1:0] act, input logic [1:0] bv);
    reset       = rst;
    active0     = act[0];
    active1     = act[1];
    byte_valid0 = bv[0];
    byte_valid1 = bv[1];
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got st/le/lu/dr/sl/err=%h required %h", name, got, exp);
  endtask

  function automatic logic [15:0] pack_out();
    return {state, lane_en, link_up, datapath_rst, start_lane, err_cnt};
  endfunction

  initial begin
    drive(1'b1, 2'b00, 2'b00);

    // Reset held, then two-lane bring-up with valids together
    v(1, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 3);
    v(0, 2'b11, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 7);
    v(0, 2'b11, 2'b00, 3'd2, 2'b11, 0, 0, 0, 8'd0, 5);
    v(0, 2'b11, 2'b11, 3'd3, 2'b11, 1, 0, 0, 8'd0, 2);
    // 3 mismatches, 1 agree, 4 mismatches -> retrain on the last
    v(0, 2'b11, 2'b01, 3'd3, 2'b11, 1, 0, 0, 8'd0, 3);
    v(0, 2'b11, 2'b11, 3'd3, 2'b11, 1, 0, 0, 8'd0, 1);
    v(0, 2'b11, 2'b10, 3'd3, 2'b11, 1, 0, 0, 8'd0, 3);
    v(0, 2'b11, 2'b10, 3'd4, 2'b00, 0, 1, 0, 8'd1, 1);
    v(0, 2'b11, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd1, 7);
    v(0, 2'b11, 2'b00, 3'd2, 2'b11, 0, 0, 0, 8'd1, 1);
    // Two-lane ALIGN, valid0 a cycle ahead of valid1
    v(0, 2'b11, 2'b01, 3'd4, 2'b00, 0, 1, 0, 8'd2, 1);
    v(0, 2'b11, 2'b10, 3'd1, 2'b00, 0, 1, 0, 8'd2, 1);
    // Mid-operation reset, then candidate change 01->11 at cnt=5
    v(1, 2'b11, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b01, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 6);
    v(0, 2'b11, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 7);
    v(0, 2'b11, 2'b00, 3'd2, 2'b11, 0, 0, 0, 8'd0, 1);
    // Lane loss in ALIGN retrains without an error; SETTLE aborts on act=00
    v(0, 2'b00, 2'b00, 3'd4, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b01, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b00, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 1);
    // Lane 1 only; valid on disabled lane 0 ignored
    v(1, 2'b10, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b10, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 7);
    v(0, 2'b10, 2'b00, 3'd2, 2'b10, 0, 0, 0, 8'd0, 1);
    v(0, 2'b10, 2'b01, 3'd2, 2'b10, 0, 0, 0, 8'd0, 1);
    v(0, 2'b10, 2'b10, 3'd3, 2'b10, 1, 0, 1, 8'd0, 2);
    // Two-lane UP, active1 drops -> retrain into lane-0-only UP
    v(1, 2'b11, 2'b00, 3'd0, 2'b00, 0, 1, 0, 8'd0, 1);
    v(0, 2'b11, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd0, 7);
    v(0, 2'b11, 2'b00, 3'd2, 2'b11, 0, 0, 0, 8'd0, 1);
    v(0, 2'b11, 2'b11, 3'd3, 2'b11, 1, 0, 0, 8'd0, 1);
    v(0, 2'b01, 2'b00, 3'd4, 2'b00, 0, 1, 0, 8'd1, 1);
    v(0, 2'b01, 2'b00, 3'd1, 2'b00, 0, 1, 0, 8'd1, 7);
    v(0, 2'b01, 2'b00, 3'd2, 2'b01, 0, 0, 0, 8'd1, 1);
    v(0, 2'b01, 2'b01, 3'd3, 2'b01, 1, 0, 0, 8'd1, 1);
    // Lane 1 waking up while single-lane UP: no upgrade, no mismatch counting
    v(0, 2'b11, 2'b01, 3'd3, 2'b01, 1, 0, 0, 8'd1, 5);
    v(0, 2'b00, 2'b01, 3'd4, 2'b00, 0, 1, 0, 8'd2, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].act, vecs[i].bv);
      @(posedge clk_4f);
      #1;
      check($sformatf("vec%0d", i), pack_out(),
            {vecs[i].st, vecs[i].le, vecs[i].lu, vecs[i].dr, vecs[i].sl, vecs[i].err});
    end

    // Repeated misalignment: one error per 9 cycles until saturation
    drive(1'b1, 2'b00, 2'b00);
    @(posedge clk_4f);
    #1;
    check("sat_reset", pack_out(), {3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0});
    drive(1'b0, 2'b11, 2'b01);
    repeat (900) @(posedge clk_4f);
    #1;
    check("sat_100", pack_out(), {3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 8'd100});
    repeat (1386) @(posedge clk_4f);
    #1;
    check("sat_254", {8'h00, err_cnt}, {8'h00, 8'd254});
    repeat (714) @(posedge clk_4f);
    #1;
    check("sat_255", pack_out(), {3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 8'd255});

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
